// File: rtl/clint_trap_ctrl_pkg.sv
// Shared encodings for the core-local trap sequencer: instruction patterns,
// CSR addresses, mcause codes, mstatus bit positions and FSM states.
package clint_trap_ctrl_pkg;

  localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INST_MRET   = 32'h3020_0073;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [31:0] CAUSE_ECALL_M    = 32'd11;
  localparam logic [31:0] CAUSE_ECALL_U    = 32'd8;
  localparam logic [31:0] CAUSE_BREAKPOINT = 32'd3;
  localparam logic [31:0] CAUSE_TIMER_DEF  = 32'h8000_0007;
  localparam logic [31:0] CAUSE_EXT_DEF    = 32'h8000_000B;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_M = 2'b11;

  // Trap and return each get their own assert state so the redirect
  // target is a pure function of the state.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_MEPC,
    ST_W_MSTATUS,
    ST_W_MCAUSE,
    ST_T_ASSERT,
    ST_R_MSTATUS,
    ST_R_ASSERT
  } trap_state_e;

  function automatic logic [31:0] csr_wr_addr(input logic [11:0] addr);
    return {20'd0, addr};
  endfunction

endpackage

// File: rtl/clint_trap_ctrl_if.sv
// EX-stage, CSR-file and redirect signals of the trap sequencer.
// master = sequencer, slave = pipeline/CSR side.
interface clint_trap_ctrl_if;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        jump_flag_i;
  logic [31:0] jump_addr_i;
  logic [1:0]  int_req_i;
  logic [1:0]  privilege_i;
  logic [31:0] csr_mtvec_i;
  logic [31:0] csr_mepc_i;
  logic [31:0] csr_mstatus_i;

  logic        clint_wr_en_o;
  logic [31:0] clint_wr_addr_o;
  logic [31:0] clint_wr_data_o;
  logic        wr_privilege_en_o;
  logic [1:0]  wr_privilege_ctrl_o;
  logic        hold_flag_o;
  logic        int_assert_o;
  logic [31:0] int_addr_o;

  modport master (
    input  inst_i, inst_addr_i, jump_flag_i, jump_addr_i, int_req_i,
           privilege_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
    output clint_wr_en_o, clint_wr_addr_o, clint_wr_data_o,
           wr_privilege_en_o, wr_privilege_ctrl_o,
           hold_flag_o, int_assert_o, int_addr_o
  );

  modport slave (
    output inst_i, inst_addr_i, jump_flag_i, jump_addr_i, int_req_i,
           privilege_i, csr_mtvec_i, csr_mepc_i, csr_mstatus_i,
    input  clint_wr_en_o, clint_wr_addr_o, clint_wr_data_o,
           wr_privilege_en_o, wr_privilege_ctrl_o,
           hold_flag_o, int_assert_o, int_addr_o
  );
endinterface

// File: rtl/clint_trap_ctrl.sv
// Trap/interrupt sequencer: stalls the pipeline, writes mepc/mstatus/mcause
// (or restores mstatus on MRET) and issues a one-cycle PC redirect.
module clint_trap_ctrl
  import clint_trap_ctrl_pkg::*;
#(
  parameter logic [31:0] CAUSE_TIMER = CAUSE_TIMER_DEF,
  parameter logic [31:0] CAUSE_EXT   = CAUSE_EXT_DEF
) (
  input  logic                     sys_clk,
  input  logic                     sys_reset,
  clint_trap_ctrl_if.master        bus
);

  trap_state_e state_reg, state_next;
  logic [31:0] saved_pc_reg, saved_pc_next;
  logic [31:0] saved_cause_reg, saved_cause_next;
  logic [1:0]  saved_priv_reg, saved_priv_next;

  logic is_ecall, is_ebreak, is_mret, sync_req, async_req, accept;

  assign is_ecall  = (bus.inst_i == INST_ECALL);
  assign is_ebreak = (bus.inst_i == INST_EBREAK);
  assign is_mret   = (bus.inst_i == INST_MRET);
  assign sync_req  = is_ecall | is_ebreak;
  assign async_req = (|bus.int_req_i) & bus.csr_mstatus_i[MSTATUS_MIE];
  // Reset gates the accept term so hold cannot leak out while in reset.
  assign accept    = (state_reg == ST_IDLE) & ~sys_reset & (sync_req | is_mret | async_req);

  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      state_reg       <= ST_IDLE;
      saved_pc_reg    <= '0;
      saved_cause_reg <= '0;
      saved_priv_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      saved_pc_reg    <= saved_pc_next;
      saved_cause_reg <= saved_cause_next;
      saved_priv_reg  <= saved_priv_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    saved_pc_next    = saved_pc_reg;
    saved_cause_next = saved_cause_reg;
    saved_priv_next  = saved_priv_reg;
    case (state_reg)
      ST_IDLE: begin
        if (sync_req) begin
          state_next       = ST_W_MEPC;
          saved_pc_next    = bus.inst_addr_i;
          saved_priv_next  = bus.privilege_i;
          if (is_ecall)
            saved_cause_next = (bus.privilege_i == PRIV_M) ? CAUSE_ECALL_M : CAUSE_ECALL_U;
          else
            saved_cause_next = CAUSE_BREAKPOINT;
        end else if (is_mret) begin
          state_next      = ST_R_MSTATUS;
          saved_priv_next = bus.privilege_i;
        end else if (async_req) begin
          state_next       = ST_W_MEPC;
          saved_pc_next    = bus.jump_flag_i ? bus.jump_addr_i : bus.inst_addr_i;
          saved_priv_next  = bus.privilege_i;
          saved_cause_next = bus.int_req_i[1] ? CAUSE_EXT : CAUSE_TIMER;
        end
      end
      ST_W_MEPC:    state_next = ST_W_MSTATUS;
      ST_W_MSTATUS: state_next = ST_W_MCAUSE;
      ST_W_MCAUSE:  state_next = ST_T_ASSERT;
      ST_T_ASSERT:  state_next = ST_IDLE;
      ST_R_MSTATUS: state_next = ST_R_ASSERT;
      ST_R_ASSERT:  state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // mstatus writes are read-modify-write on the live CSR value.
  always_comb begin
    bus.clint_wr_en_o       = 1'b0;
    bus.clint_wr_addr_o     = '0;
    bus.clint_wr_data_o     = '0;
    bus.wr_privilege_en_o   = 1'b0;
    bus.wr_privilege_ctrl_o = '0;
    bus.int_assert_o        = 1'b0;
    bus.int_addr_o          = '0;
    bus.hold_flag_o         = accept | (state_reg != ST_IDLE);
    case (state_reg)
      ST_W_MEPC: begin
        bus.clint_wr_en_o   = 1'b1;
        bus.clint_wr_addr_o = csr_wr_addr(CSR_MEPC);
        bus.clint_wr_data_o = saved_pc_reg;
      end
      ST_W_MSTATUS: begin
        bus.clint_wr_en_o   = 1'b1;
        bus.clint_wr_addr_o = csr_wr_addr(CSR_MSTATUS);
        bus.clint_wr_data_o = bus.csr_mstatus_i;
        bus.clint_wr_data_o[MSTATUS_MPIE] = bus.csr_mstatus_i[MSTATUS_MIE];
        bus.clint_wr_data_o[MSTATUS_MIE]  = 1'b0;
        bus.clint_wr_data_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = saved_priv_reg;
      end
      ST_W_MCAUSE: begin
        bus.clint_wr_en_o       = 1'b1;
        bus.clint_wr_addr_o     = csr_wr_addr(CSR_MCAUSE);
        bus.clint_wr_data_o     = saved_cause_reg;
        bus.wr_privilege_en_o   = 1'b1;
        bus.wr_privilege_ctrl_o = PRIV_M;
      end
      ST_R_MSTATUS: begin
        bus.clint_wr_en_o   = 1'b1;
        bus.clint_wr_addr_o = csr_wr_addr(CSR_MSTATUS);
        bus.clint_wr_data_o = bus.csr_mstatus_i;
        bus.clint_wr_data_o[MSTATUS_MIE]  = bus.csr_mstatus_i[MSTATUS_MPIE];
        bus.clint_wr_data_o[MSTATUS_MPIE] = 1'b1;
        bus.clint_wr_data_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = PRIV_U;
        bus.wr_privilege_en_o   = 1'b1;
        bus.wr_privilege_ctrl_o = bus.csr_mstatus_i[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
      end
      ST_T_ASSERT: begin
        bus.int_assert_o = 1'b1;
        bus.int_addr_o   = bus.csr_mtvec_i;
      end
      ST_R_ASSERT: begin
        bus.int_assert_o = 1'b1;
        bus.int_addr_o   = bus.csr_mepc_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_clint_trap_ctrl.sv
// Directed bench for clint_trap_ctrl with a tiny CSR-file model that applies
// the sequencer's writes, so read-modify-write behaviour is exercised end to end.
module tb_clint_trap_ctrl;
  import clint_trap_ctrl_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic sys_clk = 1'b0;
  logic sys_reset;
  always #5 sys_clk = ~sys_clk;

  clint_trap_ctrl_if bus();

  clint_trap_ctrl dut (
    .sys_clk   (sys_clk),
    .sys_reset (sys_reset),
    .bus       (bus)
  );

  // CSR file model; poke lets the bench preset mstatus/privilege.
  logic [31:0] mepc_q    = '0;
  logic [31:0] mstatus_q = '0;
  logic [31:0] mcause_q  = '0;
  logic [1:0]  priv_q    = '0;
  logic        poke_en;
  logic [31:0] poke_mstatus;
  logic [1:0]  poke_priv;

  always @(posedge sys_clk) begin
    if (poke_en) begin
      mstatus_q <= poke_mstatus;
      priv_q    <= poke_priv;
    end else begin
      if (bus.clint_wr_en_o) begin
        case (bus.clint_wr_addr_o[11:0])
          CSR_MEPC:    mepc_q    <= bus.clint_wr_data_o;
          CSR_MSTATUS: mstatus_q <= bus.clint_wr_data_o;
          CSR_MCAUSE:  mcause_q  <= bus.clint_wr_data_o;
          default: ;
        endcase
      end
      if (bus.wr_privilege_en_o) priv_q <= bus.wr_privilege_ctrl_o;
    end
  end

  assign bus.csr_mepc_i    = mepc_q;
  assign bus.csr_mstatus_i = mstatus_q;
  assign bus.privilege_i   = priv_q;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  function automatic logic [31:0] strobes();
    return {28'd0, bus.hold_flag_o, bus.clint_wr_en_o, bus.wr_privilege_en_o, bus.int_assert_o};
  endfunction

  task automatic poke(input logic [31:0] ms, input logic [1:0] pv);
    @(posedge sys_clk); #1;
    poke_en = 1'b1; poke_mstatus = ms; poke_priv = pv;
    @(posedge sys_clk); #1;
    poke_en = 1'b0;
  endtask

  // Steps from the accept cycle until int_assert_o; lat = cycles after accept (0 = timeout).
  task automatic wait_redirect(output int lat, output logic [31:0] addr);
    lat = 0; addr = '0;
    for (int k = 1; k <= 8; k++) begin
      @(posedge sys_clk); #1;
      if (k == 1) begin bus.inst_i = NOP; bus.jump_flag_i = 1'b0; end
      #1;
      if (bus.int_assert_o) begin lat = k; addr = bus.int_addr_o; break; end
    end
  endtask

  int          lat;
  logic [31:0] raddr;
  int          n_assert;

  initial begin
    sys_reset = 1'b1; poke_en = 1'b0; poke_mstatus = '0; poke_priv = '0;
    bus.inst_i = INST_ECALL; bus.inst_addr_i = '0; bus.jump_flag_i = 1'b0;
    bus.jump_addr_i = '0; bus.int_req_i = 2'b00; bus.csr_mtvec_i = 32'h200;

    // ECALL held during reset must not raise anything.
    repeat (2) @(posedge sys_clk); #2;
    expect_eq("reset_strobes", strobes(), 32'h0);
    expect_eq("reset_wr_data", bus.clint_wr_data_o, 32'h0);
    expect_eq("reset_int_addr", bus.int_addr_o, 32'h0);
    bus.inst_i = NOP; #1; sys_reset = 1'b0;

    // ECALL from M
    poke(32'h8, PRIV_M);
    bus.inst_i = INST_ECALL; bus.inst_addr_i = 32'h100; #1;
    expect_eq("t1_accept_hold", {31'd0, bus.hold_flag_o}, 32'd1);
    wait_redirect(lat, raddr);
    expect_eq("t1_latency", lat, 4);
    expect_eq("t1_redirect", raddr, 32'h200);
    expect_eq("t1_assert_hold", {31'd0, bus.hold_flag_o}, 32'd1);
    expect_eq("t1_mepc", mepc_q, 32'h100);
    expect_eq("t1_mstatus", mstatus_q, 32'h1880);
    expect_eq("t1_mcause", mcause_q, 32'd11);
    expect_eq("t1_priv", {30'd0, priv_q}, 32'd3);
    @(posedge sys_clk); #2;
    expect_eq("t1_hold_release", {31'd0, bus.hold_flag_o}, 32'd0);

    // ECALL from U, then MRET back to U
    poke(32'h8, PRIV_U);
    bus.inst_i = INST_ECALL; bus.inst_addr_i = 32'h104; #1;
    wait_redirect(lat, raddr);
    expect_eq("t2_latency", lat, 4);
    expect_eq("t2_mcause", mcause_q, 32'd8);
    expect_eq("t2_mstatus", mstatus_q, 32'h80);
    expect_eq("t2_priv_m", {30'd0, priv_q}, 32'd3);
    @(posedge sys_clk); #1;
    bus.inst_i = INST_MRET; bus.inst_addr_i = 32'h200; #1;
    expect_eq("t2_mret_accept", {31'd0, bus.hold_flag_o}, 32'd1);
    wait_redirect(lat, raddr);
    expect_eq("t2_mret_latency", lat, 2);
    expect_eq("t2_mret_redirect", raddr, 32'h104);
    expect_eq("t2_mret_priv", {30'd0, priv_q}, 32'd0);
    expect_eq("t2_mret_mstatus", mstatus_q, 32'h88);

    // Both interrupts, EX jumping: external wins, mepc is the jump target
    poke(32'h88, PRIV_M);
    bus.inst_addr_i = 32'h120; bus.jump_flag_i = 1'b1; bus.jump_addr_i = 32'h340;
    bus.int_req_i = 2'b11; #1;
    expect_eq("t3_accept_hold", {31'd0, bus.hold_flag_o}, 32'd1);
    wait_redirect(lat, raddr);
    expect_eq("t3_latency", lat, 4);
    expect_eq("t3_redirect", raddr, 32'h200);
    expect_eq("t3_mepc", mepc_q, 32'h340);
    expect_eq("t3_mcause", mcause_q, 32'h8000_000B);
    expect_eq("t3_mstatus", mstatus_q, 32'h1880);
    @(posedge sys_clk); #2;
    expect_eq("t3_no_reenter", strobes(), 32'h0);
    bus.int_req_i = 2'b00;

    // Timer masked by MIE=0, then taken once MIE=1
    poke(32'h0, PRIV_M);
    bus.int_req_i = 2'b01; bus.inst_addr_i = 32'h150; #1;
    expect_eq("t4_masked_hold", {31'd0, bus.hold_flag_o}, 32'd0);
    repeat (3) @(posedge sys_clk); #2;
    expect_eq("t4_masked_idle", strobes(), 32'h0);
    poke(32'h8, PRIV_M); #1;
    expect_eq("t4_accept_hold", {31'd0, bus.hold_flag_o}, 32'd1);
    wait_redirect(lat, raddr);
    expect_eq("t4_latency", lat, 4);
    expect_eq("t4_mcause", mcause_q, 32'h8000_0007);
    expect_eq("t4_mepc", mepc_q, 32'h150);
    bus.int_req_i = 2'b00;

    // ECALL and external interrupt together: sync first, interrupt after MRET
    poke(32'h8, PRIV_M);
    bus.inst_i = INST_ECALL; bus.inst_addr_i = 32'h180; bus.int_req_i = 2'b10; #1;
    wait_redirect(lat, raddr);
    expect_eq("t5_latency", lat, 4);
    expect_eq("t5_mcause", mcause_q, 32'd11);
    expect_eq("t5_mepc", mepc_q, 32'h180);
    repeat (2) @(posedge sys_clk); #2;
    expect_eq("t5_int_masked", strobes(), 32'h0);
    @(posedge sys_clk); #1;
    bus.inst_i = INST_MRET; bus.inst_addr_i = 32'h200; #1;
    wait_redirect(lat, raddr);
    expect_eq("t5_mret_latency", lat, 2);
    expect_eq("t5_mret_redirect", raddr, 32'h180);
    expect_eq("t5_mret_mstatus", mstatus_q, 32'h88);
    @(posedge sys_clk); #2;
    expect_eq("t5_int_after_mret", {31'd0, bus.hold_flag_o}, 32'd1);
    wait_redirect(lat, raddr);
    expect_eq("t5_int_latency", lat, 4);
    expect_eq("t5_int_mcause", mcause_q, 32'h8000_000B);
    expect_eq("t5_int_mepc", mepc_q, 32'h200);
    bus.int_req_i = 2'b00;

    // Reset pulsed in W_MSTATUS
    poke(32'h8, PRIV_M);
    bus.inst_i = INST_ECALL; bus.inst_addr_i = 32'h1C0; #1;
    @(posedge sys_clk); #1; bus.inst_i = NOP;
    @(posedge sys_clk); #2;
    expect_eq("t6_in_w_mstatus", bus.clint_wr_addr_o, 32'h300);
    sys_reset = 1'b1; #1;
    expect_eq("t6_reset_strobes", strobes(), 32'h0);
    @(posedge sys_clk); #1; sys_reset = 1'b0; #1;
    expect_eq("t6_after_reset", strobes(), 32'h0);
    expect_eq("t6_mepc_kept", mepc_q, 32'h1C0);
    expect_eq("t6_mstatus_untouched", mstatus_q, 32'h8);
    expect_eq("t6_mcause_untouched", mcause_q, 32'h8000_000B);
    n_assert = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge sys_clk); #2;
      if (bus.int_assert_o || bus.clint_wr_en_o) n_assert++;
    end
    expect_eq("t6_no_continuation", n_assert, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
